// File: rtl/dec_8to256.sv
// Registered binary-to-one-hot decoder: an IN_W-bit code lights one of 2^IN_W lines split into two halves.
// Optional macro DEC_HOLD_EN: idle cycles (in_valid low) keep the last decode instead of clearing it.
module dec_8to256 #(
  parameter  int IN_W   = 8,
  localparam int HALF_W = 2 ** (IN_W - 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   in0,
  input  logic              in_valid,
  output logic [HALF_W-1:0] out0,
  output logic [HALF_W-1:0] out1,
  output logic              out_valid
);

  logic [2*HALF_W-1:0] dec;
  logic [2*HALF_W-1:0] out_d, out_q;
  logic                valid_d, valid_q;

  // Each line compares against its own index, so exactly one line matches any code.
  always_comb begin
    dec = '0;
    for (int k = 0; k < 2 * HALF_W; k++) begin
      dec[k] = (in0 == IN_W'(k));
    end
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (in_valid) begin
      out_d   = dec;
      valid_d = 1'b1;
    end else begin
`ifdef DEC_HOLD_EN
      out_d   = out_q;
      valid_d = valid_q;
`else
      out_d   = '0;
      valid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out0      = out_q[HALF_W-1:0];
  assign out1      = out_q[2*HALF_W-1:HALF_W];
  assign out_valid = valid_q;

endmodule

// File: tb/tb_dec_8to256.sv
// Self-checking bench for dec_8to256: directed boundaries, full sweep, idle gaps and random traffic
// against a shift-based reference model of the full 256-bit decode.
module tb_dec_8to256;

  logic         clk;
  logic         rst_n;
  logic [7:0]   in0;
  logic         in_valid;
  logic [127:0] out0;
  logic [127:0] out1;
  logic         out_valid;

  int checkCount;
  int failCount;

  // Reference state: what {out1,out0} and out_valid must hold after the latest edge.
  logic [255:0] expVec;
  logic         expValid;

  dec_8to256 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0       (in0),
    .in_valid  (in_valid),
    .out0      (out0),
    .out1      (out1),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".vec"}, {out1, out0}, expVec);
    checkOutput({tag, ".valid"}, 256'(out_valid), 256'(expValid));
    checkOutput({tag, ".popcount"}, 256'($countones({out1, out0})), 256'($countones(expVec)));
  endtask

  // Drives one cycle of input between edges, advances the model on the edge and checks just after it.
  task automatic applyStimulus(input logic v, input logic [7:0] code, input string tag);
    @(negedge clk);
    in_valid = v;
    in0      = code;
    @(posedge clk);
    if (v) begin
      expVec   = 256'd1 << code;
      expValid = 1'b1;
    end else begin
`ifndef DEC_HOLD_EN
      expVec   = '0;
      expValid = 1'b0;
`endif
    end
    #1;
    checkAll(tag);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    expVec     = '0;
    expValid   = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in0        = 8'd5;

    // Reset held with a valid code present: nothing may be captured.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkAll("reset_hold");
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Boundary codes, including the half crossover.
    applyStimulus(1'b1, 8'd0,   "code0");
    checkOutput("code0.out0", 256'(out0), 256'd1);
    applyStimulus(1'b1, 8'd127, "code127");
    checkOutput("code127.out1", 256'(out1), 256'd0);
    applyStimulus(1'b1, 8'd128, "code128");
    checkOutput("code128.out0", 256'(out0), 256'd0);
    checkOutput("code128.out1", 256'(out1), 256'd1);
    applyStimulus(1'b1, 8'd255, "code255");

    // Back-to-back sweep of every code.
    for (int c = 0; c < 256; c++) begin
      applyStimulus(1'b1, 8'(c), "sweep");
    end

    // Idle gap after a valid decode.
    applyStimulus(1'b1, 8'd200, "gap_lead");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'($urandom_range(0, 255)), "gap_idle");
    end

    // Mid-stream asynchronous reset, asserted between edges.
    applyStimulus(1'b1, 8'd77, "pre_reset");
    #2;
    rst_n    = 1'b0;
    expVec   = '0;
    expValid = 1'b0;
    #1;
    checkAll("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'd9, "post_reset");

    // Random traffic with mixed valid and idle cycles.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
